multicycle_control: RTL

Parametrised multi-cycle control unit for the team's RV32-subset core. It accepts one instruction at a time over a valid/ready handshake and walks a DECODE/EXEC/MEM/WB state machine. For each instruction it drives the register-file write enable, the write-back source select, the ALU operation, a sign-extended immediate and a memory request. The memory request waits on a ready handshake, with a bounded timeout. The block sits between the instruction fetch stage and the datapath (register file, ALU, data memory port).

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/instr_decoder.sv | 92 +++++++++
 rtl/multicycle_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Holds the FSM state enum, instruction-class enum, opcode and ALU codes.
// Also provides the func3 -> ALU operation mapping shared by R- and I-type.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_LUI
  } instr_class_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [2:0] F3_WORD  = 3'b010;

  localparam logic [3:0] ALU_NOP    = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0001;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_PASS_B = 4'b0110;

  // Supported func3 codes for the register/immediate ALU group; NOP means unsupported.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      3'b100:  return ALU_XOR;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder for the RV32 subset.
// Produces class, ALU operation, operand-B select, sign-extended immediate
// and an illegal flag for anything outside the supported encodings.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int WIDTH_OP = 7,
  parameter int ALU_OP_W = 4
) (
  input  logic [31:0]         instr,
  output instr_class_e        cls,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic [XLEN-1:0]     imm,
  output logic                illegal
);

  logic [WIDTH_OP-1:0] opcode;
  logic [WIDTH_OP-1:0] func7;
  logic [2:0]          func3;
  logic [3:0]          f3_alu;
  logic signed [11:0]  imm_i_raw;
  logic signed [11:0]  imm_s_raw;
  logic signed [31:0]  imm_u_raw;

  assign opcode    = instr[WIDTH_OP-1:0];
  assign func7     = instr[31 -: WIDTH_OP];
  assign func3     = instr[14:12];
  assign f3_alu    = f3_to_alu(func3);
  assign imm_i_raw = instr[31:20];
  assign imm_s_raw = {instr[31:25], instr[11:7]};
  assign imm_u_raw = {instr[31:12], 12'b0};

  // Map the instruction word onto control fields; anything unmatched stays illegal.
  always_comb begin
    cls         = CLS_NONE;
    alu_op      = ALU_OP_W'(ALU_NOP);
    alu_src_imm = 1'b0;
    imm         = '0;
    illegal     = 1'b1;
    case (opcode)
      OP_R: begin
        if (func7 == F7_BASE && f3_alu != ALU_NOP) begin
          cls     = CLS_ALU;
          alu_op  = ALU_OP_W'(f3_alu);
          illegal = 1'b0;
        end else if (func7 == F7_ALT && func3 == 3'b000) begin
          cls     = CLS_ALU;
          alu_op  = ALU_OP_W'(ALU_SUB);
          illegal = 1'b0;
        end
      end
      OP_I: begin
        if (f3_alu != ALU_NOP) begin
          cls         = CLS_ALU;
          alu_op      = ALU_OP_W'(f3_alu);
          alu_src_imm = 1'b1;
          imm         = XLEN'(imm_i_raw);
          illegal     = 1'b0;
        end
      end
      OP_LOAD: begin
        if (func3 == F3_WORD) begin
          cls         = CLS_LOAD;
          alu_op      = ALU_OP_W'(ALU_ADD);
          alu_src_imm = 1'b1;
          imm         = XLEN'(imm_i_raw);
          illegal     = 1'b0;
        end
      end
      OP_STORE: begin
        if (func3 == F3_WORD) begin
          cls         = CLS_STORE;
          alu_op      = ALU_OP_W'(ALU_ADD);
          alu_src_imm = 1'b1;
          imm         = XLEN'(imm_s_raw);
          illegal     = 1'b0;
        end
      end
      OP_LUI: begin
        cls         = CLS_LUI;
        alu_op      = ALU_OP_W'(ALU_PASS_B);
        alu_src_imm = 1'b1;
        imm         = XLEN'(imm_u_raw);
        illegal     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: IDLE/DECODE/EXEC/MEM/WB sequencing per instruction.
// ALU/LUI retire in 4 cycles; loads/stores wait on mem_ready with a bounded timeout.
// instr_ready is high only in IDLE; instr_valid is ignored while busy.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int WIDTH_OP    = 7,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic                instr_ready,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_wen,
  output logic                reg_flag,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic [XLEN-1:0]     imm,
  output logic                illegal,
  output logic                bus_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e              state;
  instr_class_e        cls_q;
  logic [31:0]         instr_q;
  logic [CNT_W-1:0]    wait_cnt;

  instr_class_e        dec_cls;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_src_imm;
  logic [XLEN-1:0]     dec_imm;
  logic                dec_illegal;

  instr_decoder #(
    .XLEN     (XLEN),
    .WIDTH_OP (WIDTH_OP),
    .ALU_OP_W (ALU_OP_W)
  ) u_dec (
    .instr       (instr_q),
    .cls         (dec_cls),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .imm         (dec_imm),
    .illegal     (dec_illegal)
  );

  assign instr_ready = (state == S_IDLE);

  // Control FSM with registered outputs; pulses and strobes default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cls_q       <= CLS_NONE;
      instr_q     <= '0;
      wait_cnt    <= '0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      imm         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      reg_wen     <= 1'b0;
      reg_flag    <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      reg_wen  <= 1'b0;
      reg_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            illegal <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cls_q       <= dec_cls;
            alu_op      <= dec_alu_op;
            alu_src_imm <= dec_src_imm;
            imm         <= dec_imm;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
            mem_req  <= 1'b1;
            mem_we   <= (cls_q == CLS_STORE);
            wait_cnt <= '0;
            state    <= S_MEM;
          end else begin
            reg_wen <= 1'b1;
            state   <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (cls_q == CLS_LOAD) begin
              reg_wen  <= 1'b1;
              reg_flag <= 1'b1;
              state    <= S_WB;
            end else begin
              state <= S_IDLE;
            end
          end else if (wait_cnt == CNT_LAST) begin
            // Last permitted wait cycle expired without a response: abort.
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            bus_err  <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
